// File: rtl/chip_layer_sequencer_pkg.sv
// chip_layer_sequencer_pkg: sequencer state enum, parameter defaults and saturating increment helper
package chip_layer_sequencer_pkg;
  localparam int DEF_LAYER_W = 6;
  localparam int DEF_CNT_W = 31;
  localparam int DEF_MAX_LAYERS = 64;
  localparam int DEF_START_PULSE = 1;
  localparam int DEF_PREP_GAP = 2;
  localparam int DEF_TIMEOUT_W = 24;
  localparam int DEF_TIMEOUT_EN = 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_GAP, S_ST_START, S_ST_RUN, S_DONE} seq_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] top);
    return v == top ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/chip_layer_sequencer_if.sv
// chip_layer_sequencer_if: okFP control/status plus chip handshake bundle; master = host/chip side, slave = sequencer
interface chip_layer_sequencer_if
  import chip_layer_sequencer_pkg::*;
#(
  parameter int LAYER_W = DEF_LAYER_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic start_network;
  logic abort;
  logic [LAYER_W-1:0] n_layers;
  logic loopback_en;
  logic start_layer;
  logic done_layer;
  logic start_store;
  logic done_store;
  logic busy;
  logic done_network;
  logic timeout_err;
  logic [LAYER_W-1:0] cur_layer;
  logic [CNT_W-1:0] clk_cnt;
  logic [LAYER_W-1:0] rec_idx;
  logic [CNT_W-1:0] rec_data;
  modport master (
    output start_network, abort, n_layers, loopback_en, done_layer, done_store, rec_idx,
    input start_layer, start_store, busy, done_network, timeout_err, cur_layer, clk_cnt, rec_data
  );
  modport slave (
    input start_network, abort, n_layers, loopback_en, done_layer, done_store, rec_idx,
    output start_layer, start_store, busy, done_network, timeout_err, cur_layer, clk_cnt, rec_data
  );
endinterface

// File: rtl/chip_layer_sequencer_recorder.sv
// chip_layer_sequencer_recorder: per-layer cycle regfile; ports chip_clk, rst, write (we/idx/data), registered read (rec_idx -> rec_data, 0 beyond MAX_LAYERS)
module chip_layer_sequencer_recorder #(
  parameter int LAYER_W = 6,
  parameter int CNT_W = 31,
  parameter int MAX_LAYERS = 64
) (
  input  logic               chip_clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LAYER_W-1:0] idx,
  input  logic [CNT_W-1:0]   data,
  input  logic [LAYER_W-1:0] rec_idx,
  output logic [CNT_W-1:0]   rec_data
);
  localparam int IW = MAX_LAYERS > 1 ? $clog2(MAX_LAYERS) : 1;
  logic [CNT_W-1:0] mem [2**IW];
  always_ff @(posedge chip_clk) if (we && 32'(idx) < MAX_LAYERS) mem[idx[IW-1:0]] <= data;
  always_ff @(posedge chip_clk) rec_data <= rst || 32'(rec_idx) >= MAX_LAYERS ? '0 : mem[rec_idx[IW-1:0]];
endmodule

// File: rtl/chip_layer_sequencer.sv
// chip_layer_sequencer: launches N chip layers back to back with pulse/gap timing, cycle records, watchdog, abort; ports chip_clk, rst, bus (slave)
module chip_layer_sequencer
  import chip_layer_sequencer_pkg::*;
#(
  parameter int LAYER_W = DEF_LAYER_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int START_PULSE = DEF_START_PULSE,
  parameter int PREP_GAP = DEF_PREP_GAP,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int TIMEOUT_EN = DEF_TIMEOUT_EN
) (
  input logic chip_clk,
  input logic rst,
  chip_layer_sequencer_if.slave bus
);
  localparam int TMR_MAX = START_PULSE > PREP_GAP ? START_PULSE : PREP_GAP;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SP_LAST = TMR_W'(START_PULSE - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(PREP_GAP - 1);
  // wd starts at 0 in the first watched cycle, so this value marks the (2**TIMEOUT_W-1)th cycle
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  seq_state_t state, state_nxt;
  logic [LAYER_W-1:0] n_lat, cur_layer;
  logic lb_lat, timeout_err, idle, launch, last, rec_we, wd_exp, to_hit;
  logic [TMR_W-1:0] tmr;
  logic [TIMEOUT_W-1:0] wd;
  logic [CNT_W-1:0] clk_cnt, layer_cyc, cyc_inc;
  always_comb begin
    idle = state == S_IDLE || state == S_DONE;
    launch = idle && bus.start_network && !bus.abort;
    last = cur_layer == n_lat - LAYER_W'(1);
    rec_we = state == S_RUN && bus.done_layer && !bus.abort;
    wd_exp = TIMEOUT_EN != 0 && (state == S_RUN || state == S_ST_RUN) && wd == WD_LAST;
    to_hit = wd_exp && !bus.abort && !(state == S_RUN ? bus.done_layer : bus.done_store);
    cyc_inc = CNT_W'(sat_inc(32'(layer_cyc), CNT_MAX));
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = launch ? S_START : state;
      S_START:        state_nxt = tmr == SP_LAST ? S_RUN : S_START;
      S_RUN:          state_nxt = bus.done_layer ? (last ? (lb_lat ? S_ST_START : S_DONE) : (PREP_GAP == 0 ? S_START : S_GAP))
                                                 : (wd_exp ? S_DONE : S_RUN);
      S_GAP:          state_nxt = tmr == GAP_LAST ? S_START : S_GAP;
      S_ST_START:     state_nxt = tmr == SP_LAST ? S_ST_RUN : S_ST_START;
      S_ST_RUN:       state_nxt = bus.done_store || wd_exp ? S_DONE : S_ST_RUN;
      default:        state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end
  always_ff @(posedge chip_clk) begin
    if (rst) begin
      state <= S_IDLE;
      n_lat <= '0;
      lb_lat <= 1'b0;
      cur_layer <= '0;
      clk_cnt <= '0;
      timeout_err <= 1'b0;
      tmr <= '0;
      wd <= '0;
      layer_cyc <= '0;
    end else begin
      state <= state_nxt;
      tmr <= state_nxt == state ? tmr + 1'b1 : '0;
      wd <= state_nxt == state && (state == S_RUN || state == S_ST_RUN) ? wd + 1'b1 : '0;
      // layer_cyc holds (cycles so far - 1); the record takes cyc_inc to include the done cycle
      layer_cyc <= state_nxt == S_START && state != S_START ? '0 : cyc_inc;
      if (launch) begin
        n_lat <= bus.n_layers == '0 ? LAYER_W'(1) : bus.n_layers;
        lb_lat <= bus.loopback_en;
        cur_layer <= '0;
        clk_cnt <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (!idle) clk_cnt <= CNT_W'(sat_inc(32'(clk_cnt), CNT_MAX));
        if (rec_we && !last) cur_layer <= cur_layer + 1'b1;
        if (to_hit) timeout_err <= 1'b1;
      end
    end
  end
  assign bus.start_layer = state == S_START;
  assign bus.start_store = state == S_ST_START;
  assign bus.busy = !idle;
  assign bus.done_network = state == S_DONE;
  assign bus.timeout_err = timeout_err;
  assign bus.cur_layer = cur_layer;
  assign bus.clk_cnt = clk_cnt;
  chip_layer_sequencer_recorder #(
    .LAYER_W(LAYER_W),
    .CNT_W(CNT_W),
    .MAX_LAYERS(MAX_LAYERS)
  ) u_rec (
    .chip_clk(chip_clk),
    .rst(rst),
    .we(rec_we),
    .idx(cur_layer),
    .data(cyc_inc),
    .rec_idx(bus.rec_idx),
    .rec_data(bus.rec_data)
  );
endmodule

// File: tb/tb_chip_layer_sequencer.sv
// tb_chip_layer_sequencer: randomized runs of the layer sequencer checked against a per-run arithmetic timing model
module tb_chip_layer_sequencer;
  localparam int LW = 4, CW = 6, ML = 8, SP = 1, PG = 2, TW = 4;
  localparam int LIMIT = (1 << TW) - 1, CMAX = (1 << CW) - 1;
  logic chip_clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  int exp_rec [16];
  bit rec_ok [16];
  int dl [16];
  int n_req, ds, ab_at;
  bit lb, spam;
  chip_layer_sequencer_if #(.LAYER_W(LW), .CNT_W(CW)) bus();
  chip_layer_sequencer #(
    .LAYER_W(LW), .CNT_W(CW), .MAX_LAYERS(ML), .START_PULSE(SP),
    .PREP_GAP(PG), .TIMEOUT_W(TW), .TIMEOUT_EN(1)
  ) dut (
    .chip_clk(chip_clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 chip_clk = ~chip_clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic step();
    @(negedge chip_clk);
  endtask
  // One run: model computes pulse cycles, end cycle, counters and records from the delays,
  // then the driver answers each observed start pulse after its programmed delay.
  task automatic run_net();
    int ne, t, tot, kind, cur, st_exp, end_exp, np, pulses, st_obs, end_obs, ls, ss;
    int es [16];
    int stamp [16];
    bit psl, pst, quiet;
    ne = n_req == 0 ? 1 : n_req;
    t = 1; tot = 0; kind = 0; cur = 0; st_exp = -1; end_exp = 0; np = 0;
    for (int j = 0; j < ne; j++) begin
      cur = j; es[j] = t; np = j + 1;
      if (dl[j] > LIMIT + SP - 1) begin
        tot += SP + LIMIT; kind = 1; end_exp = t + SP + LIMIT; break;
      end
      tot += dl[j] + 1; end_exp = t + dl[j] + 1;
      if (j == ab_at) begin kind = 2; break; end
      if (j < ML) begin exp_rec[j] = dl[j] + 1; rec_ok[j] = 1'b1; end
      if (j < ne - 1) begin tot += PG; t += dl[j] + 1 + PG; end
    end
    if (kind == 0 && lb) begin
      st_exp = end_exp;
      if (ds > LIMIT + SP - 1) begin tot += SP + LIMIT; kind = 1; end_exp = st_exp + SP + LIMIT; end
      else begin tot += ds + 1; end_exp = st_exp + ds + 1; end
    end
    if (tot > CMAX) tot = CMAX;
    bus.n_layers = LW'(n_req);
    bus.loopback_en = lb;
    bus.start_network = 1'b1;
    pulses = 0; st_obs = -1; end_obs = -1; ls = 0; ss = 0; psl = 1'b0; pst = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      step();
      bus.start_network = 1'b0; bus.done_layer = 1'b0; bus.done_store = 1'b0; bus.abort = 1'b0;
      if (c == 1) begin
        chk("launch_sl", int'(bus.start_layer), 1);
        chk("launch_dn", int'(bus.done_network), 0);
        chk("launch_to", int'(bus.timeout_err), 0);
        chk("launch_cc", int'(bus.clk_cnt), 0);
        chk("launch_cur", int'(bus.cur_layer), 0);
        bus.n_layers = LW'($urandom_range(0, 15));
        bus.loopback_en = ~lb;
      end
      if (!bus.busy) begin end_obs = c; break; end
      if (bus.start_layer && !psl) begin
        if (pulses < 16) stamp[pulses] = c;
        ls = c; pulses++;
      end
      if (bus.start_store && !pst) begin st_obs = c; ss = c; end
      psl = bus.start_layer; pst = bus.start_store;
      if (pulses > 0 && pulses <= 16 && st_obs < 0 && c == ls + dl[pulses-1]) begin
        bus.done_layer = 1'b1;
        bus.abort = pulses - 1 == ab_at;
      end
      if (st_obs >= 0 && c == ss + ds) bus.done_store = 1'b1;
      if (spam && $urandom_range(0, 2) == 0) bus.start_network = 1'b1;
    end
    bus.start_network = 1'b0; bus.done_layer = 1'b0; bus.done_store = 1'b0; bus.abort = 1'b0;
    chk("end_cycle", end_obs, end_exp);
    chk("pulses", pulses, np);
    for (int j = 0; j < np && j < pulses && j < 16; j++) chk($sformatf("stamp%0d", j), stamp[j], es[j]);
    chk("store_cycle", st_obs, st_exp);
    chk("done_net", int'(bus.done_network), int'(kind != 2));
    chk("timeout", int'(bus.timeout_err), int'(kind == 1));
    chk("cur_layer", int'(bus.cur_layer), cur);
    chk("clk_cnt", int'(bus.clk_cnt), tot);
    quiet = 1'b1;
    repeat (4) begin
      step();
      if (bus.start_layer || bus.start_store) quiet = 1'b0;
    end
    chk("quiet", int'(quiet), 1);
    for (int j = 0; j < 16; j++) begin
      if (j >= ML || rec_ok[j]) begin
        bus.rec_idx = LW'(j);
        step();
        chk($sformatf("rec%0d", j), int'(bus.rec_data), j >= ML ? 0 : exp_rec[j]);
      end
    end
  endtask
  task automatic set_delays(input int v);
    for (int j = 0; j < 16; j++) dl[j] = v;
  endtask
  initial begin
    bus.start_network = 1'b0; bus.abort = 1'b0; bus.n_layers = '0; bus.loopback_en = 1'b0;
    bus.done_layer = 1'b0; bus.done_store = 1'b0; bus.rec_idx = '0;
    for (int j = 0; j < 16; j++) rec_ok[j] = 1'b0;
    repeat (3) step();
    chk("rst_sl", int'(bus.start_layer), 0);
    chk("rst_ss", int'(bus.start_store), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_dn", int'(bus.done_network), 0);
    chk("rst_to", int'(bus.timeout_err), 0);
    chk("rst_cc", int'(bus.clk_cnt), 0);
    chk("rst_cur", int'(bus.cur_layer), 0);
    chk("rst_rd", int'(bus.rec_data), 0);
    rst = 1'b0;
    step();
    n_req = 3; lb = 1'b0; ds = 3; ab_at = -1; spam = 1'b0; set_delays(5);
    run_net();
    n_req = 2; lb = 1'b1; dl[0] = 5; dl[1] = 7; ds = 4;
    run_net();
    n_req = 1; lb = 1'b0; dl[0] = 30;
    run_net();
    n_req = 3; dl[0] = 4; dl[1] = 9; dl[2] = 3; ab_at = 1;
    run_net();
    n_req = 0; ab_at = -1; spam = 1'b1; dl[0] = 15;
    run_net();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_done_dn", int'(bus.done_network), 0);
    chk("abort_done_busy", int'(bus.busy), 0);
    bus.n_layers = LW'(2); bus.start_network = 1'b1;
    step();
    bus.start_network = 1'b0;
    chk("pre_rst_sl", int'(bus.start_layer), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sl", int'(bus.start_layer), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_cc", int'(bus.clk_cnt), 0);
    chk("mid_rst_cur", int'(bus.cur_layer), 0);
    chk("mid_rst_dn", int'(bus.done_network), 0);
    step();
    n_req = 2; lb = 1'b0; spam = 1'b0; set_delays(6);
    run_net();
    for (int r = 0; r < 40; r++) begin
      n_req = int'($urandom_range(0, 10));
      lb = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) dl[j] = $urandom_range(0, 11) == 0 ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 15));
      ds = $urandom_range(0, 7) == 0 ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 15));
      ab_at = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, n_req == 0 ? 0 : n_req - 1)) : -1;
      spam = 1'($urandom_range(0, 2) == 0);
      run_net();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
